// File: rtl/fp_disp_pkg.sv
// Shared constants and types for the floating-point seven-segment display.
// Glyphs are active-low and ordered g..a, so bit 0 drives segment a.
package fp_disp_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_DIG0 = 2'd0;
    localparam digit_idx_t IDX_DIG1 = 2'd1;
    localparam digit_idx_t IDX_DIG2 = 2'd2;
    localparam digit_idx_t IDX_DIG3 = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry n is the glyph for hex value n.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex-to-segment encoder with dash and blank overrides.
// Blank takes priority over dash, which takes priority over the hex value.
module seg7_encode
    import fp_disp_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_dash,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else if (i_dash) begin
            o_seg = SEG_DASH;
        end else begin
            o_seg = HEX_GLYPH[i_value];
        end
    end

endmodule

// File: rtl/fp_seg_display.sv
// Shows a latched converter result plus a sample count on a 4-digit common-anode
// display, scanning one digit per SCAN_DIV cycles with a one-cycle blank between digits.
module fp_seg_display
    import fp_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic       i_sign,
    input  logic [2:0] i_exponent,
    input  logic [3:0] i_significand,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [1:0] o_dbg_idx
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic             r_h_sign;
    logic [2:0]       r_h_exp;
    logic [3:0]       r_h_sig;
    logic [3:0]       r_cnt;
    logic [DIV_W-1:0] r_div;
    digit_idx_t       r_idx;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic       w_tick;
    logic [3:0] w_value;
    logic       w_dash;
    logic       w_blank;
    logic [6:0] w_seg;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_sign <= 1'b0;
            r_h_exp  <= 3'd0;
            r_h_sig  <= 4'd0;
            r_cnt    <= 4'd0;
        end else if (i_valid) begin
            r_h_sign <= i_sign;
            r_h_exp  <= i_exponent;
            r_h_sig  <= i_significand;
            r_cnt    <= r_cnt + 4'd1;
        end
    end

    // The scan FSM state is the digit index; the divider sets its dwell time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= IDX_DIG0;
        end else if (w_tick) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_comb begin
        w_value = 4'd0;
        w_dash  = 1'b0;
        w_blank = 1'b0;
        case (r_idx)
            IDX_DIG0: w_value = r_cnt;
            IDX_DIG1: w_value = r_h_sig;
            IDX_DIG2: w_value = {1'b0, r_h_exp};
            default: begin
                w_dash  = r_h_sign;
                w_blank = ~r_h_sign;
            end
        endcase
    end

    seg7_encode u_encode (
        .i_value (w_value),
        .i_dash  (w_dash),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    // The tick cycle blanks everything so the old digit never bleeds into the next anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_tick) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg;
            r_dp  <= (r_idx != IDX_DIG2);
        end
    end

    assign o_an      = r_an;
    assign o_seg     = r_seg;
    assign o_dp      = r_dp;
    assign o_dbg_idx = r_idx;

endmodule

// File: tb/tb_fp_seg_display.sv
// Bench for fp_seg_display: a SCAN_DIV=4 and a SCAN_DIV=1 instance share stimulus and
// are compared every cycle against a frame-position model, plus literal spot checks.
module tb_fp_seg_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic       i_sign;
  logic [2:0] i_exponent;
  logic [3:0] i_significand;

  logic [3:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       dp4, dp1;
  logic [1:0] idx4, idx1;

  int n_checks = 0;
  int n_errors = 0;

  // model state: values the display should be showing, and edges since reset release
  int   m_edges;
  logic m_sign;
  int   m_exp, m_sig, m_cnt;
  logic p_valid, p_sign;
  int   p_exp, p_sig;
  logic [6:0] glyph [16];

  always #5 clk = ~clk;

  fp_seg_display #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sign(i_sign),
    .i_exponent(i_exponent), .i_significand(i_significand),
    .o_an(an4), .o_seg(seg4), .o_dp(dp4), .o_dbg_idx(idx4)
  );

  fp_seg_display #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sign(i_sign),
    .i_exponent(i_exponent), .i_significand(i_significand),
    .o_an(an1), .o_seg(seg1), .o_dp(dp1), .o_dbg_idx(idx1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_check(input int sd, input string tag, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp, input logic [1:0] idx);
    int p, d, ix;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    p  = m_edges - 1;
    d  = p % sd;
    ix = (p / sd) % 4;
    if (d == sd - 1) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end else begin
      e_an = 4'b1111;
      e_an[ix] = 1'b0;
      case (ix)
        0: e_seg = glyph[m_cnt];
        1: e_seg = glyph[m_sig];
        2: e_seg = glyph[m_exp];
        default: e_seg = m_sign ? 7'b0111111 : 7'b1111111;
      endcase
      e_dp = (ix != 2);
    end
    chk({tag, "_an"}, an, e_an);
    chk({tag, "_seg"}, seg, e_seg);
    chk({tag, "_dp"}, dp, e_dp);
    chk({tag, "_idx"}, idx, (m_edges / sd) % 4);
  endtask

  // compare process: the model advances by one edge per negedge
  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_edges = 0; m_sign = 1'b0; m_exp = 0; m_sig = 0; m_cnt = 0;
        chk("rst4_an", an4, 4'b1111);  chk("rst4_seg", seg4, 7'b1111111);
        chk("rst4_dp", dp4, 1'b1);     chk("rst4_idx", idx4, 2'd0);
        chk("rst1_an", an1, 4'b1111);  chk("rst1_idx", idx1, 2'd0);
      end else begin
        m_edges++;
        model_check(4, "sd4", an4, seg4, dp4, idx4);
        model_check(1, "sd1", an1, seg1, dp1, idx1);
        if (p_valid) begin
          m_sign = p_sign; m_exp = p_exp; m_sig = p_sig;
          m_cnt = (m_cnt + 1) % 16;
        end
      end
      p_valid = i_valid; p_sign = i_sign; p_exp = i_exponent; p_sig = i_significand;
    end
  end

  task automatic drive(input logic v, input logic s, input logic [2:0] e, input logic [3:0] g);
    @(posedge clk);
    #2;
    i_valid = v; i_sign = s; i_exponent = e; i_significand = g;
  endtask

  task automatic wait_an4(input logic [3:0] pat, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (an4 == pat) break;
    end
    chk(name, an4, pat);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sign = 1'b0; i_exponent = 3'd0; i_significand = 4'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (7) @(negedge clk);

    // asynchronous reset in the middle of a frame
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_an", an4, 4'b1111);
    chk("lit_async_seg", seg4, 7'b1111111);
    chk("lit_async_dp", dp4, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // single sample: sign=1, exp=3, sig=A, strobed right after the first edge
    @(posedge clk);
    #2 i_valid = 1'b1; i_sign = 1'b1; i_exponent = 3'd3; i_significand = 4'hA;
    @(negedge clk);
    #1;
    chk("lit_first_an", an4, 4'b1110);
    chk("lit_first_seg", seg4, 7'b1000000);
    chk("lit_sd1_idx1", idx1, 2'd1);
    @(posedge clk);
    #2 i_valid = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      #1;
      case (k)
        3: begin chk("lit_d0_an", an4, 4'b1110); chk("lit_d0_seg", seg4, 7'b1111001); end
        4: begin chk("lit_gap_an", an4, 4'b1111); chk("lit_sd1_idx0", idx1, 2'd0); end
        5: begin chk("lit_d1_an", an4, 4'b1101); chk("lit_d1_seg", seg4, 7'b0001000); end
        9: begin
          chk("lit_d2_an", an4, 4'b1011); chk("lit_d2_seg", seg4, 7'b0110000);
          chk("lit_d2_dp", dp4, 1'b0);
        end
        13: begin chk("lit_d3_an", an4, 4'b0111); chk("lit_d3_seg", seg4, 7'b0111111); end
        default: ;
      endcase
    end

    // counter wrap: 17 back-to-back strobes from a fresh reset
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (17) drive(1'b1, 1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    repeat (2) @(negedge clk);
    wait_an4(4'b1110, "wrap_find_d0");
    chk("lit_wrap_d0_seg", seg4, 7'b1111001);
    wait_an4(4'b0111, "wrap_find_d3");
    chk("lit_wrap_d3_seg", seg4, 7'b1111111);

    // strobe sampled on a scan tick edge
    do @(posedge clk); while (m_edges % 4 != 2);
    #2 i_valid = 1'b1; i_sign = 1'b0; i_exponent = 3'd7; i_significand = 4'd5;
    @(posedge clk);
    #2 i_valid = 1'b0;
    wait_an4(4'b1011, "sim_find_d2");
    chk("lit_sim_d2_seg", seg4, 7'b1111000);
    chk("lit_sim_cnt", dut4.r_cnt, 4'd2);

    // randomized traffic
    repeat (400) drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    drive(1'b0, 1'b0, 3'd0, 4'd0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
